// File: rtl/msrv32_store_unit.sv
// MSRV32 store path: formats rs2 into a byte-laned word write and runs the
// req/ack handshake to data memory, stalling the pipeline until it completes.
module msrv32_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic        mem_wr_req_in,
   input  logic [1:0]  funct3_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   input  logic        ms_riscv32_mp_dmwr_ack_in,
   output logic        ms_riscv32_mp_dmwr_req_out,
   output logic [31:0] ms_riscv32_mp_dmaddr_out,
   output logic [31:0] ms_riscv32_mp_dmdata_out,
   output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
   output logic        store_stall_out,
   output logic        store_done_out,
   output logic        misaligned_store_out,
   output logic        bus_err_out
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] fmt_data;
   logic [3:0]  fmt_mask;
   logic        misaligned;
   logic        accept;

   always_comb begin
      fmt_data   = rs2_in;
      fmt_mask   = 4'b1111;
      misaligned = 1'b0;
      case (funct3_in)
         2'b00: begin
            fmt_data = {4{rs2_in[7:0]}};
            fmt_mask = 4'b0001 << iadder_in[1:0];
         end
         2'b01: begin
            fmt_data   = {2{rs2_in[15:0]}};
            fmt_mask   = iadder_in[1] ? 4'b1100 : 4'b0011;
            misaligned = iadder_in[0];
         end
         default: misaligned = |iadder_in[1:0];
      endcase
   end

   assign accept = (state == IDLE) && mem_wr_req_in && !misaligned;

   // Stall is raised in the accept cycle itself so execute holds the store.
   assign store_stall_out = !ms_riscv32_mp_rst_in && ((state == BUSY) || accept);

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state                       <= IDLE;
         cnt                         <= '0;
         ms_riscv32_mp_dmwr_req_out  <= 1'b0;
         ms_riscv32_mp_dmaddr_out    <= '0;
         ms_riscv32_mp_dmdata_out    <= '0;
         ms_riscv32_mp_dmwr_mask_out <= '0;
         store_done_out              <= 1'b0;
         misaligned_store_out        <= 1'b0;
         bus_err_out                 <= 1'b0;
      end else begin
         store_done_out       <= 1'b0;
         misaligned_store_out <= 1'b0;
         bus_err_out          <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept) begin
                  state                       <= BUSY;
                  ms_riscv32_mp_dmwr_req_out  <= 1'b1;
                  ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
                  ms_riscv32_mp_dmdata_out    <= fmt_data;
                  ms_riscv32_mp_dmwr_mask_out <= fmt_mask;
               end else if (mem_wr_req_in) begin
                  misaligned_store_out <= 1'b1;
               end
            end
            BUSY: begin
               // Ack wins over a timeout landing in the same cycle.
               if (ms_riscv32_mp_dmwr_ack_in) begin
                  state                      <= IDLE;
                  ms_riscv32_mp_dmwr_req_out <= 1'b0;
                  store_done_out             <= 1'b1;
                  cnt                        <= '0;
               end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  state                      <= IDLE;
                  ms_riscv32_mp_dmwr_req_out <= 1'b0;
                  bus_err_out                <= 1'b1;
                  cnt                        <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/msrv32_store_unit.md
Name: msrv32_store_unit

Overview:
- Sequential store path for the MSRV32 core; the write-direction counterpart of the load-result path that feeds the writeback mux.
- Accepts a store request from the execute stage and formats rs2 data into a byte-laned, word-aligned data-memory write.
- Drives a request/acknowledge handshake to data memory, stalls the pipeline until completion, and flags misaligned stores and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without ack before the transaction is abandoned (range 2..255).

Ports:
- ms_riscv32_mp_clk_in  in  1  core clock; all state changes on the rising edge.
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset.
- mem_wr_req_in  in  1  store request from execute stage, sampled in IDLE only.
- funct3_in  in  2  store size: 00 SB, 01 SH, 10 SW, 11 treated as SW.
- iadder_in  in  32  effective byte address.
- rs2_in  in  32  store source data.
- ms_riscv32_mp_dmwr_ack_in  in  1  memory write acknowledge.
- ms_riscv32_mp_dmwr_req_out  out  1  memory write request.
- ms_riscv32_mp_dmaddr_out  out  32  word address: {iadder[31:2], 2'b00}.
- ms_riscv32_mp_dmdata_out  out  32  lane-replicated write data.
- ms_riscv32_mp_dmwr_mask_out  out  4  byte enables.
- store_stall_out  out  1  pipeline stall.
- store_done_out  out  1  one-cycle completion pulse.
- misaligned_store_out  out  1  one-cycle misalignment pulse.
- bus_err_out  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (async, immediate):
  - State returns to IDLE; timeout counter clears.
  - Every output is 0, including addr, data and mask.
  - A reset in the middle of a transaction drops req at once; no done or error pulse follows.
- Formatting, from funct3 and iadder[1:0]:
  - SB: data = {4{rs2[7:0]}}, mask = 4'b0001 << addr[1:0].
  - SH: data = {2{rs2[15:0]}}, mask = addr[1] ? 1100 : 0011.
  - SW: data = rs2, mask = 1111.
- Misaligned stores:
  - Definition: SH with addr[0]=1, or SW with addr[1:0]!=0.
  - Result: no bus request; misaligned_store_out pulses on the cycle after the request; state stays IDLE.
  - store_stall_out is low for a misaligned request.
- IDLE state:
  - Entry: aligned mem_wr_req_in=1.
  - Action: register addr, data and mask; go to BUSY; dmwr_req_out=1 from the next cycle.
  - store_stall_out is combinationally high in the accept cycle.
- BUSY state:
  - dmwr_req_out=1; addr, data and mask are held stable; store_stall_out=1.
  - mem_wr_req_in is ignored.
  - Ack sampled high: next cycle req=0, store_done_out=1 for 1 cycle, state IDLE, stall low.
  - Ack high on the first BUSY cycle is legal, giving a minimum latency of request -> done of 2 cycles.
  - Counter increments on every BUSY cycle without ack.
  - Counter reaches TIMEOUT_CYCLES: req drops, bus_err_out pulses 1 cycle, state IDLE.
  - Ack arriving in the same cycle the counter reaches the limit counts as success; done pulses, not error.
- Pulse and output rules:
  - done, misaligned and bus_err are mutually exclusive and never wider than 1 cycle.
  - ack received while in IDLE is ignored.
  - addr, data and mask keep their last values after completion; they are only meaningful while req=1.
- Back-to-back stores:
  - A new request in the cycle store_done_out is high is accepted; IDLE is re-entered that cycle.
  - Minimum spacing between consecutive requests is therefore 2 cycles.

Test Plan:
- Reset mid-BUSY:
  - Stimulus: SW addr 0x100, rs2 0xDEADBEEF, ack held low for 3 cycles, then assert rst.
  - Required: req/stall/addr/data/mask all 0 within the same cycle, no done pulse, next SW accepted normally.
- SB lanes:
  - Stimulus: rs2 0x11223344, addr 0x0000_2003, ack on the first BUSY cycle.
  - Required: addr 0x0000_2000, data 0x44444444, mask 1000, done pulse 2 cycles after request.
- SH upper half:
  - Stimulus: rs2 0xAABBCCDD, addr 0x0000_0012.
  - Required: data 0xCCDDCCDD, mask 1100.
- SW with delayed ack:
  - Stimulus: rs2 0x12345678, addr 0x0000_0040, ack after 5 cycles.
  - Required: req and data stable for all 5 cycles, stall high throughout, single done pulse, stall low the cycle after.
- Misaligned:
  - Stimulus: SW at 0x0000_0042, then SH at 0x0000_0001.
  - Required: misaligned_store_out pulses each time, req never asserts, stall stays 0.
- Timeout with TIMEOUT_CYCLES=4:
  - Stimulus: SW, ack held low.
  - Required: bus_err_out pulses after 4 BUSY cycles, req drops, no done pulse; repeat with ack on exactly cycle 4 and get done, no error.
